// File: rtl/word_unloader.sv
// Serialises a size-bit word LSB-first over a valid/ready bit handshake and pulses done after the last bit.
// Optional WORD_UNLOADER_PARITY_EN appends an even-parity bit after the data bits.
//
// state | meaning
// IDLE  | waiting for load; captures val on load
// SHIFT | presenting bits; one bit per accepted handshake
// DONE  | one-cycle done pulse, then back to IDLE
module word_unloader #(
    parameter int size = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [size-1:0] val,
    output logic            busy,
    output logic            bit_out,
    output logic            bit_valid,
    input  logic            bit_ready,
    output logic            done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

`ifdef WORD_UNLOADER_PARITY_EN
    localparam int NBITS = size + 1;
`else
    localparam int NBITS = size;
`endif
    localparam int CW = $clog2(size + 2);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [size-1:0] sreg;
    logic [CW-1:0]   cnt;
    logic            xfer;
    logic            capture;

    assign capture = (state == IDLE) && load;
    assign xfer    = (state == SHIFT) && bit_ready;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = load ? SHIFT : IDLE;
            SHIFT:   state_nxt = (xfer && (cnt == LAST)) ? DONE : SHIFT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                sreg <= val;
                cnt  <= '0;
            end else if (xfer) begin
                sreg <= sreg >> 1;
                cnt  <= cnt + CW'(1);
            end
        end
    end

`ifdef WORD_UNLOADER_PARITY_EN
    logic par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= 1'b0;
        end else if (capture) begin
            par <= ^val;
        end
    end

    // Once the data bits are exhausted the counter points at the parity slot.
    assign bit_out = (cnt == CW'(size)) ? par : sreg[0];
`else
    assign bit_out = sreg[0];
`endif

    assign busy      = (state == SHIFT) || (state == DONE);
    assign bit_valid = (state == SHIFT);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_word_unloader.sv
// Self-checking bench for word_unloader: table of words with expected bit streams plus reset corner cases.
module tb_word_unloader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [2:0] val;
    logic       busy;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready;
    logic       done;

    int errors = 0;
    int checks = 0;
    logic q[$];

    word_unloader #(.size(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .val       (val),
        .busy      (busy),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] v;
        int         stall;
        bit         busy_load;
        logic [3:0] exp_bits;
        int         exp_n;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, ".busy"}, {7'd0, busy}, 8'd0);
        check({name, ".valid"}, {7'd0, bit_valid}, 8'd0);
        check({name, ".done"}, {7'd0, done}, 8'd0);
        check({name, ".bit_out"}, {7'd0, bit_out}, 8'd0);
    endtask

    // Called at a negedge while IDLE; returns at a negedge with the DUT back in IDLE.
    task automatic unload(input vec_t t);
        int guard;
        int i;
        load = 1'b1;
        val  = t.v;
        for (int b = 0; b < t.exp_n; b++) q.push_back(t.exp_bits[b]);
        @(negedge clk);
        load = 1'b0;
        val  = 3'($urandom);
        check("first_valid", {7'd0, bit_valid}, 8'd1);
        check("first_busy", {7'd0, busy}, 8'd1);
        if (t.stall > 0) begin
            bit_ready = 1'b0;
            repeat (t.stall) begin
                check("stall_bit", {7'd0, bit_out}, {7'd0, q[0]});
                check("stall_valid", {7'd0, bit_valid}, 8'd1);
                check("stall_done", {7'd0, done}, 8'd0);
                @(negedge clk);
            end
        end
        bit_ready = 1'b1;
        guard = 0;
        i = 0;
        while (q.size() > 0 && guard < 40) begin
            logic exp;
            if (t.busy_load && i == 1) begin
                load = 1'b1;
                val  = 3'b011;
            end else begin
                load = 1'b0;
            end
            exp = q.pop_front();
            check("shift_valid", {7'd0, bit_valid}, 8'd1);
            check("shift_bit", {7'd0, bit_out}, {7'd0, exp});
            check("shift_done", {7'd0, done}, 8'd0);
            @(negedge clk);
            guard++;
            i++;
        end
        load = 1'b0;
        check("done_pulse", {7'd0, done}, 8'd1);
        check("done_busy", {7'd0, busy}, 8'd1);
        check("done_valid", {7'd0, bit_valid}, 8'd0);
        if (t.busy_load) begin
            load = 1'b1;
            val  = 3'b010;
        end
        @(negedge clk);
        load = 1'b0;
        check("after_done", {7'd0, done}, 8'd0);
        check("after_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        check("stay_idle", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        vec_t r;
`ifdef WORD_UNLOADER_PARITY_EN
        vecs[0] = '{3'b110, 0, 1'b0, 4'b0110, 4};
        vecs[1] = '{3'b101, 4, 1'b0, 4'b0101, 4};
        vecs[2] = '{3'b111, 0, 1'b0, 4'b1111, 4};
        vecs[3] = '{3'b011, 0, 1'b0, 4'b0011, 4};
        vecs[4] = '{3'b100, 0, 1'b1, 4'b1100, 4};
        vecs[5] = '{3'b001, 2, 1'b0, 4'b1001, 4};
`else
        vecs[0] = '{3'b110, 0, 1'b0, 4'b0110, 3};
        vecs[1] = '{3'b101, 4, 1'b0, 4'b0101, 3};
        vecs[2] = '{3'b111, 0, 1'b0, 4'b0111, 3};
        vecs[3] = '{3'b011, 0, 1'b0, 4'b0011, 3};
        vecs[4] = '{3'b100, 0, 1'b1, 4'b0100, 3};
        vecs[5] = '{3'b001, 2, 1'b0, 4'b0001, 3};
`endif
        rst       = 1'b1;
        load      = 1'b0;
        val       = 3'b000;
        bit_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_idle("idle");
        end

        foreach (vecs[k]) unload(vecs[k]);

        // Reset after the first bit is accepted: outputs drop at once, no done pulse.
        load = 1'b1;
        val  = 3'b110;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        check("mid_busy", {7'd0, busy}, 8'd1);
        check("mid_bit", {7'd0, bit_out}, 8'd1);
        #2 rst = 1'b1;
        #1 check_idle("async_rst");
        @(negedge clk);
        check_idle("held_rst");
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_idle("post_rst");
        end

        r = vecs[2];
        r.busy_load = 1'b0;
        unload(r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
